sram_bridge_2x1: RTL and testbench
==================================

Name: sram_bridge_2x1

Overview:
Arbitrates the instruction-cache miss port and the data-cache miss port onto one SRAM-like master port toward the AXI converter. It sits directly downstream of the cache wrapper's two cache-side ports. The block keeps a small in-order owner FIFO so that each mem_data_ok and mem_rdata is routed back to the requester that issued it. Data side has priority, with an anti-starvation counter protecting the instruction side.

Parameters:
MAX_OUT, 2, maximum accepted-but-unanswered transactions; owner FIFO depth (power of two, >=1)
STARVE_LIMIT, 4, consecutive data grants while inst_req waits before inst is forced to win

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
inst_req  in  1  instruction-side request
inst_wr  in  1  write flag
inst_size  in  2  0=byte 1=half 2=word
inst_addr  in  32  address
inst_wdata  in  32  write data
inst_rdata  out  32  read data
inst_addr_ok  out  1  request accepted
inst_data_ok  out  1  response valid
data_req, data_wr, data_size, data_addr, data_wdata, data_rdata, data_addr_ok, data_data_ok  same as inst_* group, data side
mem_req  out  1  master request
mem_wr  out  1  master write flag
mem_size  out  2  master size
mem_addr  out  32  master address
mem_wdata  out  32  master write data
mem_rdata  in  32  master read data
mem_addr_ok  in  1  master accept
mem_data_ok  in  1  master response
bridge_err  out  1  sticky error: mem_data_ok received with the owner FIFO empty

Behaviour:
- Clock and reset: one clock clk. Reset rst is asynchronous and active-high.
- Reset clears the owner FIFO (empty, pointers 0), lock, starve counter and bridge_err.
- With FIFO empty, all outputs are 0 after reset except inst_rdata and data_rdata, which mirror mem_rdata.
- Reset mid-transaction: all in-flight ownership is dropped. A later stray mem_data_ok sets bridge_err and is not forwarded.
- Grant selection, combinational, evaluated only when lock_valid=0:
  - forced inst if inst_req and starve_cnt==STARVE_LIMIT;
  - else data if data_req;
  - else inst if inst_req;
  - else none.
- Lock: if a grant is given and mem_addr_ok=0 that cycle, register lock_valid=1 with lock_owner=grant.
  - The grant then stays fixed until mem_addr_ok.
  - Requests are never switched mid-handshake.
- mem_req = granted requester's req AND NOT fifo_full.
- mem_wr, mem_size, mem_addr and mem_wdata are muxed from the granted side; they are 0 when there is no grant.
- When fifo_full: mem_req=0 and both *_addr_ok=0, even if a pop occurs the same cycle. The issue resumes the next cycle.
- inst_addr_ok = mem_addr_ok & mem_req & (grant==INST). data_addr_ok likewise. The accepted request is visible with zero added latency.
- Accept (mem_req & mem_addr_ok):
  - push grant into the FIFO;
  - clear lock_valid;
  - update starve_cnt: data accepted while inst_req=1 increments, saturating at STARVE_LIMIT; inst accepted resets to 0; data accepted with inst_req=0 resets to 0.
- Response (mem_data_ok):
  - if the FIFO is non-empty, pop the head;
  - assert the data_ok of the head owner in the same cycle;
  - the other side's data_ok stays 0.
- inst_rdata = data_rdata = mem_rdata, unregistered. Consumers qualify it with their own data_ok.
- Simultaneous push and pop in one cycle (not full): occupancy is unchanged and both take effect.
- An accept on the same cycle as the response to the previous transaction is legal. The response pops the old head, not the new entry.
- Response with the FIFO empty: no data_ok to either side, bridge_err<=1 (sticky until rst).
- Requester drops req while locked: lock is held. mem_req follows the requester's req, so it reads 0; arbitration stays frozen until the requester re-asserts and is accepted. Callers must follow the SRAM-like rule of holding req until addr_ok.
- Pointers wrap modulo MAX_OUT. A count register of width clog2(MAX_OUT)+1 distinguishes full from empty.

Decomposition:
- Shared package holds:
  - owner encoding: OWNER_INST=1'b0, OWNER_DATA=1'b1;
  - size encodings SIZE_BYTE=2'd0, SIZE_HALF=2'd1, SIZE_WORD=2'd2.
- One sub-module: bridge_owner_fifo.
  - Parameter: DEPTH.
  - Ports: push, push_owner, pop, head_owner, full, empty, async rst.
- Arbitration, lock and starve counter stay in the top module.

Test Plan:
- Single inst read at 0xBFC00000, mem_addr_ok same cycle, mem_data_ok 3 cycles later with rdata 0x24080001 -> inst_addr_ok pulses once and inst_data_ok pulses once with inst_rdata=0x24080001. Data side data_ok stays 0.
- inst_req and data_req asserted together, data write 0x80001000/0xDEADBEEF -> data is issued first and inst is issued after it. Responses route DATA then INST in order.
- mem_addr_ok held low 4 cycles while inst is granted and data_req rises in cycle 2 -> mem_addr stays at the inst address until accept. Data is issued next.
- data_req held continuously with inst_req waiting, always-ready memory -> after 4 consecutive data accepts, inst is accepted on the 5th grant, then starve_cnt=0.
- MAX_OUT=2, two accepts and no responses -> mem_req=0 and both addr_ok=0 until the first mem_data_ok. The third request is accepted the following cycle.
- rst asserted with 1 outstanding, then mem_data_ok -> no data_ok on either side and bridge_err=1.

Source files
------------

// File: rtl/sram_bridge_2x1_pkg.sv
// rtl/sram_bridge_2x1_pkg.sv - shared encodings for the two-to-one SRAM-like bridge
package sram_bridge_2x1_pkg;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_INST = 2'd1,
        GRANT_DATA = 2'd2
    } grant_e;

endpackage

// File: rtl/bridge_owner_fifo.sv
// rtl/bridge_owner_fifo.sv - in-order FIFO of request owners awaiting their response
module bridge_owner_fifo
    import sram_bridge_2x1_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_owner,
    input  logic pop,
    output logic head_owner,
    output logic full,
    output logic empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] r_owner;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign full       = (r_count == CW'(DEPTH));
    assign empty      = (r_count == '0);
    assign w_do_push  = push & ~full;
    assign w_do_pop   = pop & ~empty;
    assign head_owner = r_owner[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_owner[r_wr_ptr] <= push_owner;
                r_wr_ptr          <= ptr_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            // Simultaneous push and pop leaves occupancy unchanged
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/sram_bridge_2x1.sv
// rtl/sram_bridge_2x1.sv - arbitrates inst and data SRAM-like miss ports onto one master port
module sram_bridge_2x1
    import sram_bridge_2x1_pkg::*;
#(
    parameter int MAX_OUT      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    output logic        bridge_err
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic          r_lock_valid;
    logic          r_lock_owner;
    logic [SW-1:0] r_starve_cnt;
    logic          r_bridge_err;

    grant_e w_grant;
    logic   w_grant_req;
    logic   w_full;
    logic   w_empty;
    logic   w_head_owner;
    logic   w_accept;
    logic   w_push_owner;

    always_comb begin
        w_grant = GRANT_NONE;
        if (r_lock_valid) begin
            w_grant = (r_lock_owner == OWNER_DATA) ? GRANT_DATA : GRANT_INST;
        end else if (inst_req && (r_starve_cnt == SW'(STARVE_LIMIT))) begin
            w_grant = GRANT_INST;
        end else if (data_req) begin
            w_grant = GRANT_DATA;
        end else if (inst_req) begin
            w_grant = GRANT_INST;
        end
    end

    always_comb begin
        w_grant_req = 1'b0;
        mem_wr      = 1'b0;
        mem_size    = 2'd0;
        mem_addr    = 32'd0;
        mem_wdata   = 32'd0;
        case (w_grant)
            GRANT_INST: begin
                w_grant_req = inst_req;
                mem_wr      = inst_wr;
                mem_size    = inst_size;
                mem_addr    = inst_addr;
                mem_wdata   = inst_wdata;
            end
            GRANT_DATA: begin
                w_grant_req = data_req;
                mem_wr      = data_wr;
                mem_size    = data_size;
                mem_addr    = data_addr;
                mem_wdata   = data_wdata;
            end
            default: ;
        endcase
    end

    // A full owner FIFO blocks issue even when a pop lands in the same cycle
    assign mem_req      = w_grant_req & ~w_full;
    assign w_accept     = mem_req & mem_addr_ok;
    assign inst_addr_ok = w_accept & (w_grant == GRANT_INST);
    assign data_addr_ok = w_accept & (w_grant == GRANT_DATA);
    assign w_push_owner = (w_grant == GRANT_DATA) ? OWNER_DATA : OWNER_INST;

    assign inst_data_ok = mem_data_ok & ~w_empty & (w_head_owner == OWNER_INST);
    assign data_data_ok = mem_data_ok & ~w_empty & (w_head_owner == OWNER_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
    assign bridge_err   = r_bridge_err;

    bridge_owner_fifo #(
        .DEPTH(MAX_OUT)
    ) u_owner_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_accept),
        .push_owner(w_push_owner),
        .pop       (mem_data_ok),
        .head_owner(w_head_owner),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_valid <= 1'b0;
            r_lock_owner <= OWNER_INST;
            r_starve_cnt <= '0;
            r_bridge_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_lock_valid <= 1'b0;
            end else if (!r_lock_valid && (w_grant != GRANT_NONE) && !mem_addr_ok) begin
                r_lock_valid <= 1'b1;
                r_lock_owner <= w_push_owner;
            end

            if (w_accept) begin
                if ((w_grant == GRANT_DATA) && inst_req) begin
                    if (r_starve_cnt != SW'(STARVE_LIMIT)) begin
                        r_starve_cnt <= r_starve_cnt + SW'(1);
                    end
                end else begin
                    r_starve_cnt <= '0;
                end
            end

            if (mem_data_ok && w_empty) begin
                r_bridge_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_bridge_2x1.sv
// tb/tb_sram_bridge_2x1.sv - directed and random checks of sram_bridge_2x1 against a queue model
module tb_sram_bridge_2x1;
    import sram_bridge_2x1_pkg::*;

    localparam int MAX_OUT      = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, bridge_err;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    sram_bridge_2x1 #(.MAX_OUT(MAX_OUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .bridge_err(bridge_err)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: owner queue plus lock / starvation bookkeeping; grant -1 none, 0 inst, 1 data
    bit q[$];
    bit m_lock, m_lock_owner, m_err;
    int m_starve;
    int eg;
    bit e_mem_req;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_lock = 0; m_lock_owner = 0; m_err = 0; m_starve = 0;
    endfunction

    function automatic void model_eval();
        bit full, req;
        if (m_lock) eg = m_lock_owner ? 1 : 0;
        else if (inst_req && m_starve == STARVE_LIMIT) eg = 0;
        else if (data_req) eg = 1;
        else if (inst_req) eg = 0;
        else eg = -1;
        full = (q.size() == MAX_OUT);
        req = (eg == 0 && inst_req) || (eg == 1 && data_req);
        e_mem_req = req && !full;
    endfunction

    function automatic void model_update();
        bit acc;
        if (rst) begin
            model_reset();
            return;
        end
        acc = e_mem_req && mem_addr_ok;
        if (mem_data_ok) begin
            if (q.size() > 0) void'(q.pop_front());
            else m_err = 1;
        end
        if (acc) begin
            q.push_back(eg == 1 ? OWNER_DATA : OWNER_INST);
            m_lock = 0;
            if (eg == 1 && inst_req) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT;
            else m_starve = 0;
        end else if (!m_lock && eg >= 0 && !mem_addr_ok) begin
            m_lock = 1;
            m_lock_owner = (eg == 1);
        end
    endfunction

    task automatic settle();
        logic [31:0] xa, xw;
        logic [1:0]  xs;
        logic        xwr;
        bit          hd;
        #1;
        model_eval();
        xa  = (eg == 1) ? data_addr  : (eg == 0) ? inst_addr  : 32'd0;
        xw  = (eg == 1) ? data_wdata : (eg == 0) ? inst_wdata : 32'd0;
        xs  = (eg == 1) ? data_size  : (eg == 0) ? inst_size  : 2'd0;
        xwr = (eg == 1) ? data_wr    : (eg == 0) ? inst_wr    : 1'b0;
        hd  = (q.size() > 0) ? q[0] : 1'b0;
        chk("mem_req", mem_req, e_mem_req);
        chk("mem_addr", mem_addr, xa);
        chk("mem_wdata", mem_wdata, xw);
        chk("mem_size", mem_size, xs);
        chk("mem_wr", mem_wr, xwr);
        chk("inst_addr_ok", inst_addr_ok, e_mem_req && mem_addr_ok && eg == 0);
        chk("data_addr_ok", data_addr_ok, e_mem_req && mem_addr_ok && eg == 1);
        chk("inst_data_ok", inst_data_ok, mem_data_ok && q.size() > 0 && hd == OWNER_INST);
        chk("data_data_ok", data_data_ok, mem_data_ok && q.size() > 0 && hd == OWNER_DATA);
        chk("inst_rdata", inst_rdata, mem_rdata);
        chk("data_rdata", data_rdata, mem_rdata);
        chk("bridge_err", bridge_err, m_err);
    endtask

    task automatic clock();
        model_eval();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic cyc();
        settle();
        clock();
    endtask

    task automatic set_i(input logic r, input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        inst_req = r; inst_wr = w; inst_size = s; inst_addr = a; inst_wdata = d;
    endtask

    task automatic set_d(input logic r, input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        data_req = r; data_wr = w; data_size = s; data_addr = a; data_wdata = d;
    endtask

    task automatic set_m(input logic aok, input logic dok, input logic [31:0] rd);
        mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;
    endtask

    task automatic drain();
        while (q.size() > 0) begin
            set_m(0, 1, $urandom);
            cyc();
        end
        set_m(0, 0, 0);
    endtask

    initial begin
        bit ip, dp, acc_i, acc_d;
        rst = 1;
        set_i(0, 0, SIZE_BYTE, 0, 0);
        set_d(0, 0, SIZE_BYTE, 0, 0);
        set_m(0, 0, 32'h5A5A_0001);
        model_reset();
        @(negedge clk);
        settle();
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_err", bridge_err, 1'b0);
        chk("rst_rdata_mirror", inst_rdata, 32'h5A5A_0001);
        clock();
        rst = 0;
        set_m(0, 0, 0);
        cyc();

        // Single inst read, response three cycles later
        set_i(1, 0, SIZE_WORD, 32'hBFC00000, 0);
        set_m(1, 0, 0);
        settle();
        chk("t1_iaok", inst_addr_ok, 1'b1);
        chk("t1_addr", mem_addr, 32'hBFC00000);
        clock();
        set_i(0, 0, SIZE_BYTE, 0, 0);
        set_m(0, 0, 0);
        cyc();
        cyc();
        set_m(0, 1, 32'h24080001);
        settle();
        chk("t1_idok", inst_data_ok, 1'b1);
        chk("t1_rdata", inst_rdata, 32'h24080001);
        chk("t1_ddok", data_data_ok, 1'b0);
        clock();
        set_m(0, 0, 0);
        cyc();

        // Both request together: data wins, responses route DATA then INST
        set_i(1, 0, SIZE_WORD, 32'hBFC00004, 0);
        set_d(1, 1, SIZE_WORD, 32'h80001000, 32'hDEADBEEF);
        set_m(1, 0, 0);
        settle();
        chk("t2_data_first", data_addr_ok, 1'b1);
        chk("t2_inst_wait", inst_addr_ok, 1'b0);
        chk("t2_wdata", mem_wdata, 32'hDEADBEEF);
        clock();
        set_d(0, 0, SIZE_BYTE, 0, 0);
        settle();
        chk("t2_inst_second", inst_addr_ok, 1'b1);
        clock();
        set_i(0, 0, SIZE_BYTE, 0, 0);
        set_m(0, 1, 32'h11111111);
        settle();
        chk("t2_resp_data", data_data_ok, 1'b1);
        clock();
        set_m(0, 1, 32'h22222222);
        settle();
        chk("t2_resp_inst", inst_data_ok, 1'b1);
        clock();
        set_m(0, 0, 0);

        // Stalled inst handshake holds the grant while data arrives
        set_i(1, 0, SIZE_WORD, 32'hBFC00010, 0);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) set_d(1, 0, SIZE_HALF, 32'h80002000, 0);
            settle();
            chk("t3_hold_addr", mem_addr, 32'hBFC00010);
            clock();
        end
        set_m(1, 0, 0);
        settle();
        chk("t3_inst_acc", inst_addr_ok, 1'b1);
        clock();
        set_i(0, 0, SIZE_BYTE, 0, 0);
        settle();
        chk("t3_data_next", data_addr_ok, 1'b1);
        clock();
        set_d(0, 0, SIZE_BYTE, 0, 0);
        drain();

        // Starvation: four data accepts, then inst forced, then counter cleared
        set_i(1, 0, SIZE_WORD, 32'hBFC00020, 0);
        set_d(1, 0, SIZE_WORD, 32'h80003000, 0);
        for (int k = 0; k < 6; k++) begin
            set_m(1, q.size() > 0, $urandom);
            settle();
            if (k == 4) chk("t4_inst_forced", inst_addr_ok, 1'b1);
            else chk("t4_data_acc", data_addr_ok, 1'b1);
            clock();
        end
        set_i(0, 0, SIZE_BYTE, 0, 0);
        set_d(0, 0, SIZE_BYTE, 0, 0);
        drain();

        // FIFO full blocks issue, even on the popping cycle
        set_i(1, 0, SIZE_WORD, 32'hBFC00030, 0);
        set_m(1, 0, 0);
        cyc();
        cyc();
        settle();
        chk("t5_full_req", mem_req, 1'b0);
        chk("t5_full_aok", inst_addr_ok, 1'b0);
        clock();
        set_m(1, 1, 32'h33333333);
        settle();
        chk("t5_pop_req", mem_req, 1'b0);
        chk("t5_pop_aok", inst_addr_ok, 1'b0);
        clock();
        set_m(1, 0, 0);
        settle();
        chk("t5_resume", inst_addr_ok, 1'b1);
        clock();
        set_i(0, 0, SIZE_BYTE, 0, 0);
        drain();

        // Reset with one outstanding, then a stray response
        set_i(1, 0, SIZE_WORD, 32'hBFC00040, 0);
        set_m(1, 0, 0);
        cyc();
        set_i(0, 0, SIZE_BYTE, 0, 0);
        set_m(0, 0, 0);
        rst = 1;
        model_reset();
        cyc();
        rst = 0;
        set_m(0, 1, 32'h44444444);
        settle();
        chk("t6_idok", inst_data_ok, 1'b0);
        chk("t6_ddok", data_data_ok, 1'b0);
        clock();
        set_m(0, 0, 0);
        settle();
        chk("t6_err", bridge_err, 1'b1);
        clock();
        rst = 1;
        model_reset();
        cyc();
        rst = 0;

        // Random traffic obeying hold-until-addr_ok
        ip = 0;
        dp = 0;
        repeat (600) begin
            if (!ip && $urandom_range(0, 2) == 0) begin
                ip = 1;
                set_i(1, 1'($urandom), 2'($urandom_range(0, 2)), $urandom, $urandom);
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp = 1;
                set_d(1, 1'($urandom), 2'($urandom_range(0, 2)), $urandom, $urandom);
            end
            set_m(1'($urandom_range(0, 1)), (q.size() > 0) && ($urandom_range(0, 1) == 1), $urandom);
            settle();
            acc_i = e_mem_req && mem_addr_ok && eg == 0;
            acc_d = e_mem_req && mem_addr_ok && eg == 1;
            clock();
            if (acc_i) begin
                ip = 0;
                set_i(0, 0, SIZE_BYTE, 0, 0);
            end
            if (acc_d) begin
                dp = 0;
                set_d(0, 0, SIZE_BYTE, 0, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
